// File: rtl/oser_tx_if.sv
// Word stream into the serialiser: valid/ready handshake with a WIDTH-bit payload.
interface oser_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tvalid_i;
    logic             tready_o;
    logic [WIDTH-1:0] tdata_i;

    modport master (output tvalid_i, output tdata_i, input tready_o);
    modport slave  (input tvalid_i, input tdata_i, output tready_o);
endinterface

// File: rtl/oser_tx.sv
// WIDTH:1 parallel-to-serial transmitter, LSB first, with word strobe and
// training-burst insertion for far-end deserialiser bit alignment.
module oser_tx #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] TRAIN       = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] IDLE        = WIDTH'(8'h00),
    parameter int unsigned      TRAIN_WORDS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       train_i,
    oser_tx_if.slave   s,
    output logic       sdata_o,
    output logic       frame_o,
    output logic       train_o
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TW = 8;
    localparam logic [CW-1:0] LAST       = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TRAIN_LOAD = TW'(TRAIN_WORDS - 1);

    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic             latch, latch_n;
    logic             sdata_n, frame_n, train_n;
    logic [WIDTH-1:0] word;
    logic             load_c, pend_c;

    // A load cycle is the last bit slot of the counter; training holds off new data.
    assign load_c     = (cnt == LAST);
    assign pend_c     = latch | (tcnt != '0);
    assign s.tready_o = load_c & ~pend_c;

    always_comb begin
        cnt_n   = cnt + CW'(1);
        sreg_n  = sreg >> 1;
        sdata_n = sreg[0];
        frame_n = 1'b0;
        tcnt_n  = tcnt;
        latch_n = latch | train_i;
        word    = IDLE;
        if (load_c) begin
            cnt_n   = '0;
            frame_n = 1'b1;
            // Latch clears on the boundary unless train_i re-asserts in this cycle.
            latch_n = train_i;
            if (pend_c) begin
                word   = TRAIN;
                tcnt_n = latch ? TRAIN_LOAD : (tcnt - TW'(1));
            end else if (s.tvalid_i) begin
                word = s.tdata_i;
            end
            sdata_n = word[0];
            sreg_n  = word >> 1;
        end
        train_n = latch_n | (tcnt_n != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= LAST;
            sreg    <= '0;
            tcnt    <= '0;
            latch   <= 1'b0;
            sdata_o <= 1'b0;
            frame_o <= 1'b0;
            train_o <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            tcnt    <= tcnt_n;
            latch   <= latch_n;
            sdata_o <= sdata_n;
            frame_o <= frame_n;
            train_o <= train_n;
        end
    end
endmodule
